// File: rtl/score_post_pkg.sv
// Shared types, FP32 field constants and ordering helpers for the post-score stage.
package score_post_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FINAL,
    S_DONE
  } state_t;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned FP_W     = 32;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;

  localparam logic [7:0]      EXP_MAX   = 8'hFF;
  localparam logic [FP_W-1:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic fp32_is_nan(input logic [FP_W-1:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_MAX) && (v[EXP_LSB-1:0] != '0);
  endfunction

  // Monotonic unsigned key: -0 sorts just below +0, negatives reversed.
  function automatic logic [FP_W-1:0] fp32_order_key(input logic [FP_W-1:0] v);
    return v[SIGN_BIT] ? ~v : (v ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp32_max_sel.sv
// Combinational running-max update step: folds one candidate score into a row's max/idx/nan.
module fp32_max_sel
  import score_post_pkg::*;
(
  input  logic [FP_W-1:0]  i_cur_max,
  input  logic [COL_W-1:0] i_cur_idx,
  input  logic             i_cur_nan,
  input  logic             i_first,
  input  logic [FP_W-1:0]  i_cand,
  input  logic [COL_W-1:0] i_cand_col,
  output logic [FP_W-1:0]  o_max,
  output logic [COL_W-1:0] o_idx,
  output logic             o_nan
);

  logic [FP_W-1:0]  w_base_max;
  logic [COL_W-1:0] w_base_idx;
  logic             w_base_nan;
  logic             w_cand_nan;
  logic             w_base_empty;
  logic             w_take;

  // A canonical-NaN base marks a row that has not yet seen a non-NaN value.
  assign w_base_max   = i_first ? CANON_NAN : i_cur_max;
  assign w_base_idx   = i_first ? '0 : i_cur_idx;
  assign w_base_nan   = i_first ? 1'b0 : i_cur_nan;
  assign w_cand_nan   = fp32_is_nan(i_cand);
  assign w_base_empty = fp32_is_nan(w_base_max);
  assign w_take       = !w_cand_nan &&
                        (w_base_empty || (fp32_order_key(i_cand) > fp32_order_key(w_base_max)));

  assign o_max = w_take ? i_cand : w_base_max;
  assign o_idx = w_take ? i_cand_col : w_base_idx;
  assign o_nan = w_base_nan | w_cand_nan;

endmodule

// File: rtl/score_row_argmax.sv
// Reads the 4x4 FP32 score tile, finds each row's max and argmax, and publishes scaled results.
module score_row_argmax
  import score_post_pkg::*;
#(
  parameter int unsigned SCALE_SHIFT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         score_rd_en,
  output logic [3:0]   score_rd_addr,
  input  logic [31:0]  score_rd_data,
  output logic [127:0] row_max_flat,
  output logic [7:0]   row_idx_flat,
  output logic [3:0]   row_nan,
  output logic         busy,
  output logic         done
);

  localparam logic [7:0] SHIFT8    = 8'(SCALE_SHIFT);
  localparam logic [3:0] LAST_ADDR = 4'd15;

  state_t           r_state;
  logic             r_cap_vld;
  logic [3:0]       r_cap_addr;
  logic [FP_W-1:0]  r_max [ROWS];
  logic [COL_W-1:0] r_idx [ROWS];
  logic             r_nan [ROWS];

  logic [1:0]       w_row;
  logic [COL_W-1:0] w_col;
  logic             w_first;
  logic [FP_W-1:0]  w_new_max;
  logic [COL_W-1:0] w_new_idx;
  logic             w_new_nan;
  logic [127:0]     w_max_flat;
  logic [7:0]       w_idx_flat;
  logic [3:0]       w_nan;

  // Divide by 2^SCALE_SHIFT via exponent decrement; underflow flushes to signed zero.
  function automatic logic [FP_W-1:0] scale_max(input logic [FP_W-1:0] v);
    logic [7:0] e;
    e = v[EXP_MSB:EXP_LSB];
    if (e == EXP_MAX) begin
      return v;
    end else if (e <= SHIFT8) begin
      return {v[SIGN_BIT], 31'b0};
    end else begin
      return {v[SIGN_BIT], 8'(e - SHIFT8), v[EXP_LSB-1:0]};
    end
  endfunction

  assign w_row   = r_cap_addr[3:2];
  assign w_col   = r_cap_addr[1:0];
  assign w_first = (w_col == '0);

  fp32_max_sel u_max_sel (
    .i_cur_max  (r_max[w_row]),
    .i_cur_idx  (r_idx[w_row]),
    .i_cur_nan  (r_nan[w_row]),
    .i_first    (w_first),
    .i_cand     (score_rd_data),
    .i_cand_col (w_col),
    .o_max      (w_new_max),
    .o_idx      (w_new_idx),
    .o_nan      (w_new_nan)
  );

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_flat
    assign w_max_flat[32*gi +: 32] = scale_max(r_max[gi]);
    assign w_idx_flat[2*gi +: 2]   = r_idx[gi];
    assign w_nan[gi]               = r_nan[gi];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cap_vld     <= 1'b0;
      r_cap_addr    <= '0;
      score_rd_en   <= 1'b0;
      score_rd_addr <= '0;
      row_max_flat  <= '0;
      row_idx_flat  <= '0;
      row_nan       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int unsigned i = 0; i < ROWS; i++) begin
        r_max[i] <= '0;
        r_idx[i] <= '0;
        r_nan[i] <= 1'b0;
      end
    end else begin
      done       <= 1'b0;
      r_cap_vld  <= score_rd_en;
      r_cap_addr <= score_rd_addr;
      if (r_cap_vld) begin
        r_max[w_row] <= w_new_max;
        r_idx[w_row] <= w_new_idx;
        r_nan[w_row] <= w_new_nan;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_READ;
            score_rd_en   <= 1'b1;
            score_rd_addr <= '0;
            busy          <= 1'b1;
          end
        end
        S_READ: begin
          if (score_rd_addr == LAST_ADDR) begin
            r_state       <= S_DRAIN;
            score_rd_en   <= 1'b0;
            score_rd_addr <= '0;
          end else begin
            score_rd_addr <= score_rd_addr + 4'd1;
          end
        end
        S_DRAIN: r_state <= S_FINAL;
        S_FINAL: begin
          row_max_flat <= w_max_flat;
          row_idx_flat <= w_idx_flat;
          row_nan      <= w_nan;
          done         <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          score_rd_en <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_row_argmax.sv
// Scoreboard bench for score_row_argmax: reference model, score-memory model and output monitor.
module tb_score_row_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start;
  logic         score_rd_en;
  logic [3:0]   score_rd_addr;
  logic [31:0]  score_rd_data;
  logic [127:0] row_max_flat;
  logic [7:0]   row_idx_flat;
  logic [3:0]   row_nan;
  logic         busy, done;

  logic         d0_en;
  logic [3:0]   d0_addr;
  logic [127:0] d0_max;
  logic [7:0]   d0_idx;
  logic [3:0]   d0_nan;
  logic         d0_busy, d0_done;

  score_row_argmax #(.SCALE_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .score_rd_en(score_rd_en), .score_rd_addr(score_rd_addr), .score_rd_data(score_rd_data),
    .row_max_flat(row_max_flat), .row_idx_flat(row_idx_flat), .row_nan(row_nan),
    .busy(busy), .done(done)
  );

  score_row_argmax #(.SCALE_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .score_rd_en(d0_en), .score_rd_addr(d0_addr), .score_rd_data(score_rd_data),
    .row_max_flat(d0_max), .row_idx_flat(d0_idx), .row_nan(d0_nan),
    .busy(d0_busy), .done(d0_done)
  );

  typedef struct {
    logic [127:0] max3;
    logic [127:0] max0;
    logic [7:0]   idx;
    logic [3:0]   nan;
    int           exp_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] scores [16];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  logic [127:0] held_max, held_max0;
  logic [7:0]   held_idx;
  logic [3:0]   held_nan;

  always @(posedge clk) cyc <= cyc + 1;

  // Score block model: data appears the cycle after the read request.
  always @(posedge clk) if (score_rd_en) score_rd_data <= scores[score_rd_addr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic is_nan_ref(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // a > b in real-number order, with -0 below +0.
  function automatic logic gt_ref(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic [31:0] scale_ref(input logic [31:0] v, input int s);
    int e;
    e = int'(v[30:23]);
    if (e == 255) return v;
    if (e <= s) return {v[31], 31'd0};
    return {v[31], 8'(e - s), v[22:0]};
  endfunction

  function automatic exp_t model();
    exp_t r;
    r.max3 = '0; r.max0 = '0; r.idx = '0; r.nan = '0; r.exp_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] best;
      logic        have;
      logic [1:0]  bi;
      logic        anynan;
      best = 32'h7FC0_0000; have = 1'b0; bi = 2'd0; anynan = 1'b0;
      for (int j = 0; j < 4; j++) begin
        logic [31:0] v;
        v = scores[4*i+j];
        if (is_nan_ref(v)) anynan = 1'b1;
        else if (!have || gt_ref(v, best)) begin
          best = v; bi = 2'(j); have = 1'b1;
        end
      end
      r.max3[32*i +: 32] = scale_ref(best, 3);
      r.max0[32*i +: 32] = scale_ref(best, 0);
      r.idx[2*i +: 2]    = bi;
      r.nan[i]           = anynan;
    end
    return r;
  endfunction

  function automatic logic [31:0] int_to_fp(input int unsigned n);
    int          p;
    logic [31:0] m;
    p = 0;
    for (int b = 0; b < 24; b++) if (n[b]) p = b;
    m = n << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return {r[31], 8'hFF, r[22:1], 1'b1};
      1:       return {r[31], 31'd0};
      2:       return {r[31], 8'hFF, 23'd0};
      3:       return {r[31], 8'h00, r[22:0]};
      4:       return {r[31], 8'($urandom_range(0, 5)), r[22:0]};
      5, 6:    return {r[31], 8'd128, 23'd0};
      default: return r;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic launch(output int c0);
    step();
    start = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run_expect(input exp_t e_in);
    exp_t e;
    int   c0;
    e = e_in;
    launch(c0);
    e.exp_cyc = c0 + 19;
    sb.push_back(e);
    wait_to(c0 + 20);
  endtask

  task automatic randomize_scores();
    for (int k = 0; k < 16; k++) begin
      if ((k % 4) != 0 && $urandom_range(0, 3) == 0) scores[k] = scores[k-1];
      else scores[k] = rand_fp();
    end
  endtask

  // Monitor: pops the scoreboard on each done and checks outputs hold otherwise.
  always @(negedge clk) begin
    if (cyc > 20000) begin
      n_chk++;
      n_fail++;
      $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
    if (!rst) begin
      en_cnt    = 0;
      held_max  = '0;
      held_max0 = '0;
      held_idx  = '0;
      held_nan  = '0;
    end else begin
      chk("dut0_lockstep", 128'({d0_en, d0_addr, d0_done, d0_busy, d0_idx, d0_nan}),
          128'({score_rd_en, score_rd_addr, done, busy, row_idx_flat, row_nan}));
      if (done) begin
        chk("done_expected", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("done_latency", 128'(cyc), 128'(mon_e.exp_cyc));
          chk("row_max", row_max_flat, mon_e.max3);
          chk("row_max_shift0", d0_max, mon_e.max0);
          chk("row_idx", 128'(row_idx_flat), 128'(mon_e.idx));
          chk("row_nan", 128'(row_nan), 128'(mon_e.nan));
          chk("busy_at_done", 128'(busy), 128'(1));
          chk("rd_en_cycles", 128'(en_cnt), 128'(16));
          held_max  = mon_e.max3;
          held_max0 = mon_e.max0;
          held_idx  = mon_e.idx;
          held_nan  = mon_e.nan;
        end
        en_cnt = 0;
      end else begin
        chk("hold_max", row_max_flat, held_max);
        chk("hold_max_shift0", d0_max, held_max0);
        chk("hold_idx_nan", 128'({row_idx_flat, row_nan}), 128'({held_idx, held_nan}));
      end
      if (score_rd_en) begin
        chk("rd_addr", 128'(score_rd_addr), 128'(en_cnt[3:0]));
        en_cnt++;
      end else begin
        chk("rd_addr_idle", 128'(score_rd_addr), 128'(0));
      end
    end
  end

  initial begin
    exp_t e;
    int   c0;
    rst   = 1'b0;
    start = 1'b0;
    score_rd_data = '0;
    for (int k = 0; k < 16; k++) scores[k] = '0;
    step();
    step();
    chk("reset_rd_en", 128'(score_rd_en), 128'(0));
    chk("reset_rd_addr", 128'(score_rd_addr), 128'(0));
    chk("reset_row_max", row_max_flat, 128'(0));
    chk("reset_row_idx", 128'(row_idx_flat), 128'(0));
    chk("reset_row_nan", 128'(row_nan), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    rst = 1'b1;
    step();

    // Standard pattern: score(i,j) = 64(i+1)(j+1)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        scores[4*i+j] = int_to_fp(32'(64 * (i + 1) * (j + 1)));
    e = model();
    e.max3 = {32'h4300_0000, 32'h42C0_0000, 32'h4280_0000, 32'h4200_0000};
    e.idx  = 8'hFF;
    e.nan  = 4'h0;
    run_expect(e);

    // Ties, negatives, signed zeros, all-NaN row
    scores = '{32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000,
               32'hBF80_0000, 32'hC040_0000, 32'hBF00_0000, 32'hC000_0000,
               32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000,
               32'h7FC0_0001, 32'hFFFF_FFFF, 32'h7F80_0001, 32'h7FC0_0000};
    e = model();
    e.max3 = {32'h7FC0_0000, 32'h0000_0000, 32'hBD80_0000, 32'h3F20_0000};
    e.idx  = 8'h08;
    e.nan  = 4'b1000;
    run_expect(e);

    // NaN skipping and scaling edges
    scores = '{32'h7F80_0001, 32'h3F80_0000, 32'h4000_0000, 32'hFFC0_0000,
               32'h0080_0000, 32'h0000_0001, 32'h8000_0000, 32'h807F_FFFF,
               32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 32'hFF80_0000,
               32'h4080_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h3F00_0000};
    e = model();
    e.max3 = {32'h3F00_0000, 32'h7F80_0000, 32'h0000_0000, 32'h3E80_0000};
    e.max0[127:96] = 32'h4080_0000;
    e.idx  = 8'h12;
    e.nan  = 4'b0001;
    run_expect(e);

    for (int r = 0; r < 40; r++) begin
      randomize_scores();
      run_expect(model());
    end

    // start pulses mid-run and in the done cycle are ignored
    randomize_scores();
    e = model();
    launch(c0);
    e.exp_cyc = c0 + 19;
    sb.push_back(e);
    wait_to(c0 + 5);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_to(c0 + 19);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_to(c0 + 45);

    // Reset in cycle 10 of a run discards it entirely
    randomize_scores();
    e = model();
    launch(c0);
    e.exp_cyc = c0 + 19;
    sb.push_back(e);
    wait_to(c0 + 10);
    rst = 1'b0;
    sb.delete();
    step();
    chk("midrst_rd_en", 128'(score_rd_en), 128'(0));
    chk("midrst_rd_addr", 128'(score_rd_addr), 128'(0));
    chk("midrst_row_max", row_max_flat, 128'(0));
    chk("midrst_idx_nan", 128'({row_idx_flat, row_nan}), 128'(0));
    chk("midrst_busy_done", 128'({busy, done}), 128'(0));
    step();
    rst = 1'b1;
    wait_to(c0 + 45);
    chk("midrst_idle", 128'({busy, score_rd_en}), 128'(0));

    // start held high: back-to-back runs every 20 cycles
    randomize_scores();
    e = model();
    step();
    start = 1'b1;
    c0 = cyc;
    for (int r = 0; r < 3; r++) begin
      e.exp_cyc = c0 + 19 + 20 * r;
      sb.push_back(e);
    end
    wait_to(c0 + 41);
    start = 1'b0;
    wait_to(c0 + 70);

    for (int r = 0; r < 10; r++) begin
      randomize_scores();
      run_expect(model());
    end

    wait_to(cyc + 5);
    chk("pending_done", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
